key_conditioner: RTL and testbench



---
 rtl/key_conditioner.sv | 152 +++++++++++++++
 tb/tb_key_conditioner.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/key_conditioner.sv
// key_conditioner: turns raw active-low push-buttons into clean, registered
// per-key press/release/long-press strobes plus a debounced pressed level.
// Each key has its own synchronizer, debounce FSM and hold counter, so
// events on different keys never interact.
module key_conditioner #(
  parameter int N_KEYS          = 3,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 50000000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key_n,
  output logic [N_KEYS-1:0] o_press,
  output logic [N_KEYS-1:0] o_release,
  output logic [N_KEYS-1:0] o_long,
  output logic [N_KEYS-1:0] o_level
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES);
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(LONG_CYCLES - 1);
  localparam logic [HW-1:0] H_MAX  = HW'(LONG_CYCLES);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_e;

  logic [N_KEYS-1:0] sync1_q, sync1_d;
  logic [N_KEYS-1:0] sync2_q, sync2_d;
  logic [N_KEYS-1:0] pressed_s;

  state_e        state_q [N_KEYS];
  state_e        state_d [N_KEYS];
  logic [DW-1:0] dcnt_q  [N_KEYS];
  logic [DW-1:0] dcnt_d  [N_KEYS];
  logic [HW-1:0] hcnt_q  [N_KEYS];
  logic [HW-1:0] hcnt_d  [N_KEYS];

  logic [N_KEYS-1:0] press_q, press_d;
  logic [N_KEYS-1:0] release_q, release_d;
  logic [N_KEYS-1:0] long_q, long_d;
  logic [N_KEYS-1:0] level_q, level_d;

  // Two-stage synchronizer feeding a pressed (active-high) sample per key.
  always_comb begin
    sync1_d   = i_key_n;
    sync2_d   = sync1_q;
    pressed_s = ~sync2_q;
  end

  // Per-key debounce FSM, hold counter and next values of all registered outputs.
  // The hold counter keeps running through a release bounce so a brief glitch
  // while held does not delay or re-arm the long-press strobe.
  always_comb begin
    for (int k = 0; k < N_KEYS; k++) begin
      state_d[k]   = state_q[k];
      dcnt_d[k]    = dcnt_q[k];
      hcnt_d[k]    = hcnt_q[k];
      press_d[k]   = 1'b0;
      release_d[k] = 1'b0;
      long_d[k]    = 1'b0;

      case (state_q[k])
        IDLE: begin
          if (pressed_s[k]) begin
            state_d[k] = PRESS_WAIT;
            dcnt_d[k]  = '0;
          end
        end
        PRESS_WAIT: begin
          if (!pressed_s[k]) begin
            state_d[k] = IDLE;
          end else if (dcnt_q[k] == D_LAST) begin
            state_d[k] = HELD;
            hcnt_d[k]  = '0;
            press_d[k] = 1'b1;
          end else begin
            dcnt_d[k] = dcnt_q[k] + 1'b1;
          end
        end
        HELD: begin
          if (!pressed_s[k]) begin
            state_d[k] = RELEASE_WAIT;
            dcnt_d[k]  = '0;
          end
        end
        RELEASE_WAIT: begin
          if (pressed_s[k]) begin
            state_d[k] = HELD;
          end else if (dcnt_q[k] == D_LAST) begin
            state_d[k]   = IDLE;
            release_d[k] = 1'b1;
          end else begin
            dcnt_d[k] = dcnt_q[k] + 1'b1;
          end
        end
        default: begin
          state_d[k] = IDLE;
        end
      endcase

      if (state_q[k] == HELD || state_q[k] == RELEASE_WAIT) begin
        if (hcnt_q[k] != H_MAX) begin
          hcnt_d[k] = hcnt_q[k] + 1'b1;
        end
        long_d[k] = (hcnt_q[k] == H_LAST);
      end

      level_d[k] = (state_d[k] == HELD) || (state_d[k] == RELEASE_WAIT);
    end
  end

  // State, counters, synchronizer and output registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync1_q   <= '1;
      sync2_q   <= '1;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      level_q   <= '0;
      for (int k = 0; k < N_KEYS; k++) begin
        state_q[k] <= IDLE;
        dcnt_q[k]  <= '0;
        hcnt_q[k]  <= '0;
      end
    end else begin
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      level_q   <= level_d;
      for (int k = 0; k < N_KEYS; k++) begin
        state_q[k] <= state_d[k];
        dcnt_q[k]  <= dcnt_d[k];
        hcnt_q[k]  <= hcnt_d[k];
      end
    end
  end

  assign o_press   = press_q;
  assign o_release = release_q;
  assign o_long    = long_q;
  assign o_level   = level_q;

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner: directed latency checks followed by random
// per-key button activity, all compared every cycle against a behavioural
// model built from run-lengths of the synchronized key samples.
module tb_key_conditioner;

   localparam int N_KEYS          = 3;
   localparam int DEBOUNCE_CYCLES = 4;
   localparam int LONG_CYCLES     = 20;

   logic              clk;
   logic              rst;
   logic [N_KEYS-1:0] keyN;
   logic [N_KEYS-1:0] oPress;
   logic [N_KEYS-1:0] oRelease;
   logic [N_KEYS-1:0] oLong;
   logic [N_KEYS-1:0] oLevel;

   int checks;
   int errors;

   // Model state: synchronizer pipeline, accepted level, length of the
   // current run of samples disagreeing with that level, edges since press.
   logic [N_KEYS-1:0] pipe1;
   logic [N_KEYS-1:0] pipe2;
   logic [N_KEYS-1:0] modelLevel;
   int                runLen [N_KEYS];
   int                since  [N_KEYS];
   logic [N_KEYS-1:0] expPress;
   logic [N_KEYS-1:0] expRelease;
   logic [N_KEYS-1:0] expLong;

   key_conditioner #(
      .N_KEYS          (N_KEYS),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .LONG_CYCLES     (LONG_CYCLES)
   ) dut (
      .i_clk     (clk),
      .i_rst     (rst),
      .i_key_n   (keyN),
      .o_press   (oPress),
      .o_release (oRelease),
      .o_long    (oLong),
      .o_level   (oLevel)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   // Advance the model by one clock edge using the inputs the DUT samples.
   task automatic modelStep(input logic r, input logic [N_KEYS-1:0] kn);
      logic s;
      logic oldLevel;
      expPress   = '0;
      expRelease = '0;
      expLong    = '0;
      if (r) begin
         pipe1      = '1;
         pipe2      = '1;
         modelLevel = '0;
         for (int k = 0; k < N_KEYS; k++) begin
            runLen[k] = 0;
            since[k]  = 0;
         end
      end else begin
         for (int k = 0; k < N_KEYS; k++) begin
            s        = ~pipe2[k];
            oldLevel = modelLevel[k];
            if (oldLevel) begin
               if (since[k] + 1 == LONG_CYCLES) expLong[k] = 1'b1;
               if (since[k] < 1000000) since[k] = since[k] + 1;
            end
            if (s != oldLevel) runLen[k] = runLen[k] + 1;
            else runLen[k] = 0;
            if (runLen[k] == DEBOUNCE_CYCLES + 1) begin
               runLen[k]     = 0;
               modelLevel[k] = ~oldLevel;
               if (!oldLevel) begin
                  expPress[k] = 1'b1;
                  since[k]    = 0;
               end else begin
                  expRelease[k] = 1'b1;
               end
            end
         end
         pipe2 = pipe1;
         pipe1 = kn;
      end
   endtask

   // Drive one cycle of inputs, clock it, and compare all outputs to the model.
   task automatic applyStimulus(input logic r, input logic [N_KEYS-1:0] kn);
      rst  = r;
      keyN = kn;
      @(posedge clk);
      modelStep(r, kn);
      @(negedge clk);
      checkOutput("press",   32'(oPress),   32'(expPress));
      checkOutput("release", 32'(oRelease), 32'(expRelease));
      checkOutput("long",    32'(oLong),    32'(expLong));
      checkOutput("level",   32'(oLevel),   32'(modelLevel));
   endtask

   int pressAt;
   int longAt;
   int longCount;
   int remaining [N_KEYS];
   logic [N_KEYS-1:0] randKeys;
   logic randRst;

   // Directed latency checks, then randomized activity on all keys.
   initial begin
      checks     = 0;
      errors     = 0;
      pipe1      = '1;
      pipe2      = '1;
      modelLevel = '0;
      for (int k = 0; k < N_KEYS; k++) begin
         runLen[k] = 0;
         since[k]  = 0;
      end
      rst  = 1'b1;
      keyN = '1;
      @(negedge clk);

      applyStimulus(1'b1, 3'b111);
      applyStimulus(1'b1, 3'b111);
      checkOutput("resetLevel", 32'(oLevel), 32'd0);
      checkOutput("resetPress", 32'(oPress), 32'd0);
      applyStimulus(1'b0, 3'b111);

      // Clean press on key 0: strobe after E0+6, long 20 edges after that.
      pressAt   = -1;
      longAt    = -1;
      longCount = 0;
      for (int n = 0; n < 40; n++) begin
         applyStimulus(1'b0, 3'b110);
         if (oPress[0] && pressAt < 0) pressAt = n;
         if (oLong[0]) begin
            longCount++;
            if (longAt < 0) longAt = n;
         end
      end
      checkOutput("pressLatency", 32'(pressAt), 32'd6);
      checkOutput("longLatency",  32'(longAt),  32'd26);
      checkOutput("longOnce",     32'(longCount), 32'd1);
      checkOutput("heldLevel",    32'(oLevel), 32'b001);
      for (int n = 0; n < 10; n++) applyStimulus(1'b0, 3'b111);
      checkOutput("releasedLevel", 32'(oLevel), 32'b000);

      // Simultaneous fall of keys 0 and 2.
      pressAt = -1;
      for (int n = 0; n < 12; n++) begin
         applyStimulus(1'b0, 3'b010);
         if (oPress != 3'b000 && pressAt < 0) begin
            pressAt = n;
            checkOutput("simulPress", 32'(oPress), 32'b101);
         end
      end
      checkOutput("simulLatency", 32'(pressAt), 32'd6);
      for (int n = 0; n < 10; n++) applyStimulus(1'b0, 3'b111);

      // Randomized per-key toggling with mixed glitch, medium and long holds.
      for (int k = 0; k < N_KEYS; k++) remaining[k] = 1;
      randKeys = '1;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         for (int k = 0; k < N_KEYS; k++) begin
            remaining[k]--;
            if (remaining[k] <= 0) begin
               int sel;
               randKeys[k] = ~randKeys[k];
               sel = int'($urandom_range(0, 9));
               if (sel < 4)      remaining[k] = int'($urandom_range(1, 3));
               else if (sel < 7) remaining[k] = int'($urandom_range(4, 12));
               else              remaining[k] = int'($urandom_range(22, 45));
            end
         end
         randRst = ($urandom_range(0, 299) == 0);
         applyStimulus(randRst, randKeys);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
